tnn_feature_loader: RTL and testbench
=====================================

TNN_FEATURE_LOADER -- requirements
Module: tnn_feature_loader

Interface
REQ-001 Parameter FEAT_W, default 8, width of each raw feature sample.
REQ-002 Parameter Q_SHIFT, default 5, right-shift applied before 3-bit quantization.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 s_valid  input  1  upstream raw feature beat valid.
REQ-006 s_ready  output  1  loader accepts the beat this cycle.
REQ-007 s_data  input  FEAT_W  raw unsigned feature value; beats arrive in order a,b,c,d,e.
REQ-008 s_last  input  1  marks the fifth (e) beat of a sample.
REQ-009 m_valid  output  1  quantized 5-feature vector available to the neuron stage.
REQ-010 m_ready  input  1  neuron stage consumes the vector.
REQ-011 m_a, m_b, m_c, m_d, m_e  output  3 each  quantized features, wired directly to the neuron core's 3-bit inputs a..e.
REQ-012 frame_err  output  1  one-cycle pulse on a framing violation.
REQ-013 sample_cnt  output  16  count of vectors pushed to the output buffer.

Function
REQ-014 A beat transfers when s_valid & s_ready; m-side transfer when m_valid & m_ready.
REQ-015 Quantization: q = min(7, s_data >> Q_SHIFT), unsigned; default gives s_data[7:5].
REQ-016 Feature index idx (0..4) selects the assembly slot; each accepted beat writes q into slot idx, then idx increments.
REQ-017 FSM states: COLLECT (idx 0..3), LAST (idx 4, buffer has room), STALL (idx 4, buffer full).
REQ-018 COLLECT->LAST when idx reaches 4 and buffer not full; COLLECT->STALL when idx reaches 4 and buffer full; STALL->LAST when buffer has room; LAST->COLLECT on accepted beat.
REQ-019 s_ready = 1 in COLLECT and LAST, 0 in STALL; s_ready has no combinational path from m_ready.
REQ-020 Accepted beat at idx 4 with s_last=1: assembled vector pushed into the 2-entry output FIFO next edge, idx <- 0, sample_cnt increments.
REQ-021 Latency: completing beat accepted at edge t with FIFO empty -> m_valid=1 and m_a..m_e valid after edge t+1.
REQ-022 Framing violation (s_last=1 at idx<4, or s_last=0 at idx 4): beat consumed, partial sample discarded, idx <- 0, frame_err=1 for one cycle, nothing pushed.
REQ-023 Simultaneous push and pop on a full FIFO: not possible (STALL); on non-full FIFO both occur, occupancy unchanged, order preserved.
REQ-024 m_a..m_e hold stable while m_valid=1 and m_ready=0.
REQ-025 sample_cnt wraps 65535 -> 0 without error indication.
REQ-026 Output FIFO is first-in-first-out, depth exactly 2, m_valid = FIFO non-empty.

Reset
REQ-027 On rst_n=0, immediately: idx=0, state COLLECT, FIFO empty, m_valid=0, frame_err=0, sample_cnt=0, m_a..m_e=0, s_ready=1 after deassertion.
REQ-028 Reset mid-sample discards the partial sample and buffered vectors; no frame_err is raised for it.

Structure
REQ-029 Shared package tnn_loader_pkg holds Q_W=3, NFEAT=5, the FSM state enum, and the packed 5x3-bit feature-vector typedef.
REQ-030 The output buffer is a separate sub-module tnn_fifo2 (2-entry, 15-bit payload, same clk/rst_n).

Verification
REQ-031 Beats 0x20,0x40,0x60,0x80,0xFF(last), m_ready=1 -> one cycle later m_valid=1, m_a..m_e = 1,2,3,4,7; sample_cnt=1.
REQ-032 Q_SHIFT=3, s_data=0xFF -> quantized value saturates to 7.
REQ-033 m_ready=0, three back-to-back samples -> two buffered, s_ready=0 at idx 4 of third; m_ready=1 -> vectors emerge in order, third completes, none lost.
REQ-034 s_last=1 on third beat -> frame_err pulse, no m_valid; next five well-formed beats produce a correct vector.
REQ-035 rst_n low after 2 beats and with one vector buffered -> m_valid=0, sample_cnt=0 immediately; next full sample outputs correctly.
REQ-036 65536 samples pushed -> sample_cnt reads 0.

Source files
------------

// File: rtl/tnn_loader_pkg.sv
// Shared types for the TNN feature loader: quantized feature width, feature
// count, loader FSM states and the packed 5x3-bit feature vector.
package tnn_loader_pkg;
  localparam int Q_W   = 3;
  localparam int NFEAT = 5;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_LAST    = 2'd1,
    ST_STALL   = 2'd2
  } ld_state_e;

  // Field a sits in the MSBs so {a,b,c,d,e} concatenations map directly.
  typedef struct packed {
    logic [Q_W-1:0] a;
    logic [Q_W-1:0] b;
    logic [Q_W-1:0] c;
    logic [Q_W-1:0] d;
    logic [Q_W-1:0] e;
  } feat_vec_t;
endpackage

// File: rtl/tnn_fifo2.sv
// Two-entry first-in-first-out buffer for assembled feature vectors.
// The head entry is presented on o_data and only moves when popped.
module tnn_fifo2
  import tnn_loader_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_push,
  input  feat_vec_t i_data,
  input  logic      i_pop,
  output logic      o_valid,
  output logic      o_full,
  output feat_vec_t o_data
);
  feat_vec_t  r_mem [2];
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       w_push;
  logic       w_pop;

  assign w_pop  = i_pop && (r_count != 2'd0);
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 2'd1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 2'd1;
      end
    end
  end

  assign o_valid = (r_count != 2'd0);
  assign o_full  = (r_count == 2'd2);
  assign o_data  = r_mem[r_rd_ptr];
endmodule

// File: rtl/tnn_feature_loader.sv
// Collects five raw feature beats (a..e), quantizes each to 3 bits and hands
// the assembled vector to the neuron core through a 2-entry output buffer.
module tnn_feature_loader
  import tnn_loader_pkg::*;
#(
  parameter int FEAT_W  = 8,
  parameter int Q_SHIFT = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [FEAT_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [Q_W-1:0]    m_a,
  output logic [Q_W-1:0]    m_b,
  output logic [Q_W-1:0]    m_c,
  output logic [Q_W-1:0]    m_d,
  output logic [Q_W-1:0]    m_e,
  output logic              frame_err,
  output logic [15:0]       sample_cnt,
  output ld_state_e         o_dbg_state
);
  // Handshake: a transfer happens on any rising edge where valid & ready are
  // both high; valid never waits on ready, and s_ready depends on state only.
  ld_state_e         r_state;
  ld_state_e         w_state_nxt;
  logic [2:0]        r_idx;
  logic [Q_W-1:0]    r_slot [4];
  logic              r_pend;
  feat_vec_t         r_pend_vec;
  logic              r_frame_err;
  logic [15:0]       r_sample_cnt;
  logic [FEAT_W-1:0] w_shifted;
  logic [Q_W-1:0]    w_q;
  logic              w_acc;
  logic              w_pop;
  logic              w_fifo_full;
  logic              w_full_after;
  logic              w_frame_viol;
  logic              w_complete;
  feat_vec_t         w_head;

  assign w_shifted = s_data >> Q_SHIFT;
  assign w_q       = (w_shifted > FEAT_W'(7)) ? 3'd7 : w_shifted[Q_W-1:0];

  assign s_ready      = (r_state != ST_STALL);
  assign w_acc        = s_valid && s_ready;
  assign w_pop        = m_valid && m_ready;
  // Buffer occupancy as it will be after this edge; no push can coincide.
  assign w_full_after = w_fifo_full && !w_pop;
  assign w_frame_viol = w_acc && (s_last != (r_idx == 3'd4));
  assign w_complete   = w_acc && s_last && (r_idx == 3'd4);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_COLLECT: begin
        if (w_acc && !s_last && (r_idx == 3'd3)) begin
          w_state_nxt = w_full_after ? ST_STALL : ST_LAST;
        end
      end
      ST_LAST: begin
        if (w_acc) begin
          w_state_nxt = ST_COLLECT;
        end
      end
      ST_STALL: begin
        if (!w_full_after) begin
          w_state_nxt = ST_LAST;
        end
      end
      default: w_state_nxt = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_COLLECT;
      r_idx        <= 3'd0;
      r_pend       <= 1'b0;
      r_pend_vec   <= '0;
      r_frame_err  <= 1'b0;
      r_sample_cnt <= 16'd0;
      for (int i = 0; i < 4; i++) begin
        r_slot[i] <= '0;
      end
    end else begin
      r_state     <= w_state_nxt;
      r_frame_err <= w_frame_viol;
      r_pend      <= w_complete;
      if (w_complete) begin
        r_pend_vec <= {r_slot[0], r_slot[1], r_slot[2], r_slot[3], w_q};
      end
      if (r_pend) begin
        r_sample_cnt <= r_sample_cnt + 16'd1;
      end
      if (w_acc) begin
        if (w_frame_viol || w_complete) begin
          r_idx <= 3'd0;
        end else begin
          r_slot[r_idx[1:0]] <= w_q;
          r_idx              <= r_idx + 3'd1;
        end
      end
    end
  end

  tnn_fifo2 u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_pend),
    .i_data  (r_pend_vec),
    .i_pop   (m_ready),
    .o_valid (m_valid),
    .o_full  (w_fifo_full),
    .o_data  (w_head)
  );

  assign m_a         = w_head.a;
  assign m_b         = w_head.b;
  assign m_c         = w_head.c;
  assign m_d         = w_head.d;
  assign m_e         = w_head.e;
  assign frame_err   = r_frame_err;
  assign sample_cnt  = r_sample_cnt;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_tnn_feature_loader.sv
// Bench for tnn_feature_loader: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a sample-level reference model.
module tb_tnn_feature_loader;
  import tnn_loader_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (default Q_SHIFT) ----------------
  logic        s_valid, s_ready, s_last, m_valid, m_ready, frame_err;
  logic [7:0]  s_data;
  logic [2:0]  m_a, m_b, m_c, m_d, m_e;
  logic [15:0] sample_cnt;
  ld_state_e   dbg_state;
  logic        rr_mode, m_ready_dir, m_ready_rnd;

  assign m_ready = rr_mode ? m_ready_rnd : m_ready_dir;

  tnn_feature_loader #(.FEAT_W(8), .Q_SHIFT(5)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
    .m_a(m_a), .m_b(m_b), .m_c(m_c), .m_d(m_d), .m_e(m_e),
    .frame_err(frame_err), .sample_cnt(sample_cnt), .o_dbg_state(dbg_state)
  );

  // ---------------- second DUT with Q_SHIFT=3 ----------------
  logic        q3_s_valid, q3_s_ready, q3_s_last, q3_m_valid, q3_frame_err;
  logic [7:0]  q3_s_data;
  logic [2:0]  q3_a, q3_b, q3_c, q3_d, q3_e;
  logic [15:0] q3_cnt;
  ld_state_e   q3_state;

  tnn_feature_loader #(.FEAT_W(8), .Q_SHIFT(3)) dut_q3 (
    .clk(clk), .rst_n(rst_n), .s_valid(q3_s_valid), .s_ready(q3_s_ready),
    .s_data(q3_s_data), .s_last(q3_s_last), .m_valid(q3_m_valid), .m_ready(1'b1),
    .m_a(q3_a), .m_b(q3_b), .m_c(q3_c), .m_d(q3_d), .m_e(q3_e),
    .frame_err(q3_frame_err), .sample_cnt(q3_cnt), .o_dbg_state(q3_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] quant(input logic [7:0] d, input int sh);
    int v;
    v = int'(d) >> sh;
    return (v > 7) ? 3'd7 : 3'(v);
  endfunction

  // Model: expected buffer contents, position within the current sample,
  // the vector completed last edge (it enters the buffer one edge later).
  logic [14:0] exp_q[$];
  int          pos;
  logic [2:0]  part [4];
  bit          pend_v;
  logic [14:0] pend;
  bit          exp_ferr;
  logic [15:0] exp_cnt;
  bit          exp_sr, mpop, macc;
  logic [2:0]  mq;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      pos = 0; pend_v = 0; exp_ferr = 0; exp_cnt = 16'd0;
      chk("reset_m_valid", 32'(m_valid), 32'd0);
      chk("reset_frame_err", 32'(frame_err), 32'd0);
      chk("reset_sample_cnt", 32'(sample_cnt), 32'd0);
      chk("reset_m_vec", 32'({m_a, m_b, m_c, m_d, m_e}), 32'd0);
      chk("reset_s_ready", 32'(s_ready), 32'd1);
    end else begin
      exp_sr = (pos < 4) || (exp_q.size() < 2);
      chk("s_ready", 32'(s_ready), 32'(exp_sr));
      chk("m_valid", 32'(m_valid), 32'(exp_q.size() != 0));
      chk("frame_err", 32'(frame_err), 32'(exp_ferr));
      chk("sample_cnt", 32'(sample_cnt), 32'(exp_cnt));
      if (exp_q.size() != 0) begin
        chk("m_vec", 32'({m_a, m_b, m_c, m_d, m_e}), 32'(exp_q[0]));
      end
      mpop = m_ready && (exp_q.size() != 0);
      macc = s_valid && exp_sr;
      if (mpop) void'(exp_q.pop_front());
      if (pend_v) begin
        exp_q.push_back(pend);
        exp_cnt = exp_cnt + 16'd1;
        pend_v = 0;
      end
      exp_ferr = 0;
      if (macc) begin
        mq = quant(s_data, 5);
        if (pos < 4 && !s_last) begin
          part[pos] = mq;
          pos++;
        end else if (pos == 4 && s_last) begin
          pend = {part[0], part[1], part[2], part[3], mq};
          pend_v = 1;
          pos = 0;
        end else begin
          exp_ferr = 1;
          pos = 0;
        end
      end
    end
  end

  // ---------------- random m_ready ----------------
  always @(posedge clk) begin
    #1 m_ready_rnd = ($urandom_range(0, 3) != 0);
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last);
    int n;
    n = 0;
    s_valid = 1'b1; s_data = d; s_last = last;
    @(negedge clk);
    while (!s_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      checks++; failures++;
      $display("FAIL send_beat_timeout: s_ready stayed %0b, required 1", s_ready);
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_sample(input logic [7:0] a, b, c, d, e);
    send_beat(a, 1'b0); send_beat(b, 1'b0); send_beat(c, 1'b0);
    send_beat(d, 1'b0); send_beat(e, 1'b1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  logic [7:0] q3_beats [5];

  initial begin
    s_valid = 0; s_data = 0; s_last = 0;
    rr_mode = 0; m_ready_dir = 1; m_ready_rnd = 1;
    q3_s_valid = 0; q3_s_data = 0; q3_s_last = 0;
    tick(2);
    chk("lit_reset_m_valid", 32'(m_valid), 32'd0);
    chk("lit_reset_cnt", 32'(sample_cnt), 32'd0);
    rst_n = 1'b1;
    tick(1);
    chk("lit_s_ready_after_reset", 32'(s_ready), 32'd1);
    chk("lit_state_collect", 32'(dbg_state), 32'(ST_COLLECT));
    chk("lit_model_quant_sat", 32'(quant(8'hFF, 3)), 32'd7);

    // Basic vector and latency
    send_sample(8'h20, 8'h40, 8'h60, 8'h80, 8'hFF);
    chk("lit_latency_not_yet", 32'(m_valid), 32'd0);
    tick(1);
    chk("lit_basic_m_valid", 32'(m_valid), 32'd1);
    chk("lit_basic_vec", 32'({m_a, m_b, m_c, m_d, m_e}), 32'({3'd1, 3'd2, 3'd3, 3'd4, 3'd7}));
    chk("lit_basic_cnt", 32'(sample_cnt), 32'd1);
    tick(2);

    // Early s_last: framing error, then recovery
    send_beat(8'h10, 1'b0); send_beat(8'h20, 1'b0); send_beat(8'h30, 1'b1);
    chk("lit_ferr_pulse", 32'(frame_err), 32'd1);
    chk("lit_ferr_no_valid", 32'(m_valid), 32'd0);
    tick(1);
    chk("lit_ferr_one_cycle", 32'(frame_err), 32'd0);
    send_sample(8'h00, 8'h20, 8'h40, 8'hE0, 8'h60);
    tick(1);
    chk("lit_recover_vec", 32'({m_a, m_b, m_c, m_d, m_e}), 32'({3'd0, 3'd1, 3'd2, 3'd7, 3'd3}));
    tick(2);

    // Backpressure: two buffered, third stalls at its last beat
    m_ready_dir = 0;
    send_sample(8'h20, 8'h20, 8'h20, 8'h20, 8'h20);
    send_sample(8'h40, 8'h40, 8'h40, 8'h40, 8'h40);
    send_beat(8'h60, 1'b0); send_beat(8'h60, 1'b0);
    send_beat(8'h60, 1'b0); send_beat(8'h60, 1'b0);
    tick(2);
    chk("lit_stall_s_ready", 32'(s_ready), 32'd0);
    chk("lit_stall_state", 32'(dbg_state), 32'(ST_STALL));
    chk("lit_stall_head", 32'({m_a, m_b, m_c, m_d, m_e}), 32'({5{3'd1}}));
    m_ready_dir = 1;
    tick(1);
    chk("lit_unstall_head", 32'({m_a, m_b, m_c, m_d, m_e}), 32'({5{3'd2}}));
    chk("lit_unstall_ready", 32'(s_ready), 32'd1);
    send_beat(8'h60, 1'b1);
    tick(4);
    chk("lit_backpressure_cnt", 32'(sample_cnt), 32'd5);
    chk("lit_drained", 32'(m_valid), 32'd0);

    // Reset mid-sample with a vector buffered
    m_ready_dir = 0;
    send_sample(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    send_beat(8'h20, 1'b0); send_beat(8'h20, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("lit_rst_m_valid", 32'(m_valid), 32'd0);
    chk("lit_rst_cnt", 32'(sample_cnt), 32'd0);
    chk("lit_rst_ferr", 32'(frame_err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_ready_dir = 1;
    tick(1);
    send_sample(8'hFF, 8'hE0, 8'hA0, 8'h60, 8'h1F);
    tick(1);
    chk("lit_post_rst_vec", 32'({m_a, m_b, m_c, m_d, m_e}), 32'({3'd7, 3'd7, 3'd5, 3'd3, 3'd0}));
    chk("lit_post_rst_cnt", 32'(sample_cnt), 32'd1);
    tick(2);

    // Randomized traffic with occasional framing violations
    rr_mode = 1;
    for (int s = 0; s < 300; s++) begin
      for (int b = 0; b < 5; b++) begin
        logic lst;
        lst = (b == 4);
        if ($urandom_range(0, 11) == 0) lst = ~lst;
        send_beat(8'($urandom_range(0, 255)), lst);
        if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
      end
    end
    rr_mode = 0;
    m_ready_dir = 1;
    tick(10);
    chk("lit_final_drained", 32'(m_valid), 32'd0);

    // Q_SHIFT=3 instance: saturation of large values
    q3_beats[0] = 8'hFF; q3_beats[1] = 8'h08; q3_beats[2] = 8'h10;
    q3_beats[3] = 8'h3F; q3_beats[4] = 8'h00;
    for (int i = 0; i < 5; i++) begin
      chk("lit_q3_s_ready", 32'(q3_s_ready), 32'd1);
      q3_s_valid = 1'b1; q3_s_data = q3_beats[i]; q3_s_last = (i == 4);
      tick(1);
    end
    q3_s_valid = 1'b0; q3_s_last = 1'b0;
    tick(1);
    chk("lit_q3_valid", 32'(q3_m_valid), 32'd1);
    chk("lit_q3_vec", 32'({q3_a, q3_b, q3_c, q3_d, q3_e}), 32'({3'd7, 3'd1, 3'd2, 3'd7, 3'd0}));
    chk("lit_q3_cnt", 32'(q3_cnt), 32'd1);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
